// File: rtl/mod3_frame_acc_pkg.sv
// Shared definitions for the mod-3 frame accumulator.
//   state_t       : frame FSM states (IDLE = no frame open, ACCUM = frame open)
//   MOD3          : modulus, 3-bit so it compares directly against a 2+2 bit sum
//   ILLEGAL_CODE  : the only non-residue 2-bit code; treated as 0 and flagged
//   DEFAULT_CNT_W : default width of the per-frame word counter
package mod3_frame_acc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [2:0] MOD3          = 3'd3;
  localparam logic [1:0] ILLEGAL_CODE  = 2'b11;
  localparam int         DEFAULT_CNT_W = 16;

endpackage

// File: rtl/mod3_frame_acc_add.sv
// mod3_add: combinational (a + b) mod 3 for residues in 0..2.
//   a, b : input  [1:0] residues (0..2)
//   y    : output [1:0] (a + b) mod 3
// The largest legal sum is 4, so one conditional subtract of 3 is enough.
module mod3_add
  import mod3_frame_acc_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [1:0] y
);

  logic [2:0] sum;
  logic [2:0] red;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    red = (sum >= MOD3) ? (sum - MOD3) : sum;
    y   = red[1:0];
  end

endmodule

// File: rtl/mod3_frame_acc.sv
// mod3_frame_acc: residue mod 3 of a multi-word big integer delivered as a
// stream of per-word remainders. Since 2^32 mod 3 = 1, the frame residue is
// the sum of the word remainders mod 3.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input handshake (in_ready = !out_valid || out_ready)
//   in_r [1:0]            : word remainder (3 is illegal: counted as 0, flagged)
//   in_last               : final word of the frame
//   out_valid / out_ready : result handshake; result held until taken
//   out_res [1:0]         : frame residue mod 3
//   out_cnt [CNT_W-1:0]   : words in frame, saturating
//   out_sat               : word count saturated during the frame
//   out_err               : an illegal in_r was seen during the frame
// Optional (macro MOD3_FRAME_CHK_EN):
//   exp_res [1:0]         : expected residue, sampled with the accepted last word
//   out_mismatch          : registered exp_res != computed residue
module mod3_frame_acc
  import mod3_frame_acc_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_r,
  input  logic             in_last,
`ifdef MOD3_FRAME_CHK_EN
  input  logic [1:0]       exp_res,
  output logic             out_mismatch,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_res,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_sat,
  output logic             out_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Frame state
  state_t           state_reg, state_next;
  logic [1:0]       acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sat_reg, sat_next;
  logic             err_reg, err_next;

  // Output holding register
  logic             out_valid_reg, out_valid_next;
  logic [1:0]       out_res_reg, out_res_next;
  logic [CNT_W-1:0] out_cnt_reg, out_cnt_next;
  logic             out_sat_reg, out_sat_next;
  logic             out_err_reg, out_err_next;

  // Per-word datapath
  logic             accept;
  logic             first;
  logic             illegal;
  logic [1:0]       in_clean;
  logic [1:0]       acc_base;
  logic [1:0]       acc_sum;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_at_max;
  logic             sat_upd;
  logic             err_upd;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // A word arriving in IDLE opens a frame, so it starts from a zero base;
  // this also makes a stale acc/count impossible to leak into a new frame.
  assign first    = (state_reg == IDLE);
  assign illegal  = (in_r == ILLEGAL_CODE);
  assign in_clean = illegal ? 2'd0 : in_r;
  assign acc_base = first ? 2'd0 : acc_reg;
  assign cnt_base = first ? '0 : cnt_reg;

  mod3_add u_add (
    .a (acc_base),
    .b (in_clean),
    .y (acc_sum)
  );

  // Saturation is flagged when a word arrives with the count already pinned,
  // i.e. the true word count exceeds what out_cnt can represent.
  assign cnt_at_max = (cnt_base == CNT_MAX);
  assign cnt_inc    = cnt_at_max ? cnt_base : (cnt_base + CNT_ONE);
  assign sat_upd    = (first ? 1'b0 : sat_reg) | cnt_at_max;
  assign err_upd    = (first ? 1'b0 : err_reg) | illegal;

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    sat_next       = sat_reg;
    err_next       = err_reg;
    out_valid_next = out_valid_reg;
    out_res_next   = out_res_reg;
    out_cnt_next   = out_cnt_reg;
    out_sat_next   = out_sat_reg;
    out_err_next   = out_err_reg;

    // Consumer took the result; a simultaneous last word below overrides this
    // so the output register reloads without a bubble.
    if (out_ready) begin
      out_valid_next = 1'b0;
    end

    if (accept) begin
      if (in_last) begin
        state_next     = IDLE;
        acc_next       = 2'd0;
        cnt_next       = '0;
        sat_next       = 1'b0;
        err_next       = 1'b0;
        out_valid_next = 1'b1;
        out_res_next   = acc_sum;
        out_cnt_next   = cnt_inc;
        out_sat_next   = sat_upd;
        out_err_next   = err_upd;
      end else begin
        state_next = ACCUM;
        acc_next   = acc_sum;
        cnt_next   = cnt_inc;
        sat_next   = sat_upd;
        err_next   = err_upd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= 2'd0;
      cnt_reg       <= '0;
      sat_reg       <= 1'b0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_res_reg   <= 2'd0;
      out_cnt_reg   <= '0;
      out_sat_reg   <= 1'b0;
      out_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      sat_reg       <= sat_next;
      err_reg       <= err_next;
      out_valid_reg <= out_valid_next;
      out_res_reg   <= out_res_next;
      out_cnt_reg   <= out_cnt_next;
      out_sat_reg   <= out_sat_next;
      out_err_reg   <= out_err_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_res   = out_res_reg;
  assign out_cnt   = out_cnt_reg;
  assign out_sat   = out_sat_reg;
  assign out_err   = out_err_reg;

`ifdef MOD3_FRAME_CHK_EN
  // Compare result is loaded in the same cycle as out_res, so it always
  // describes the frame currently held at the output.
  logic mismatch_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_reg <= 1'b0;
    end else if (accept && in_last) begin
      mismatch_reg <= (exp_res != acc_sum);
    end
  end

  assign out_mismatch = mismatch_reg;
`endif

endmodule

// File: tb/tb_mod3_frame_acc.sv
// Directed testbench for mod3_frame_acc (CNT_W = 4 so saturation is reachable).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_mod3_frame_acc;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_r;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_res;
  logic [CNT_W-1:0] out_cnt;
  logic             out_sat;
  logic             out_err;
`ifdef MOD3_FRAME_CHK_EN
  logic [1:0]       exp_res;
  logic             out_mismatch;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mod3_frame_acc #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_last   (in_last),
`ifdef MOD3_FRAME_CHK_EN
    .exp_res   (exp_res),
    .out_mismatch (out_mismatch),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_cnt   (out_cnt),
    .out_sat   (out_sat),
    .out_err   (out_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one word for one cycle (accepted if in_ready is high).
  task automatic word(input logic [1:0] r, input logic last);
    in_valid = 1'b1;
    in_r     = r;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_r     = 2'd0;
  endtask

  task automatic result(input string tag, input logic v, input logic [1:0] r,
                        input logic [CNT_W-1:0] c, input logic s, input logic e);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".res"},   32'(out_res),   32'(r));
    chk({tag, ".cnt"},   32'(out_cnt),   32'(c));
    chk({tag, ".sat"},   32'(out_sat),   32'(s));
    chk({tag, ".err"},   32'(out_err),   32'(e));
    $display("txn %s: valid=%0d res=%0d cnt=%0d sat=%0d err=%0d",
             tag, out_valid, out_res, out_cnt, out_sat, out_err);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_r      = 2'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
`ifdef MOD3_FRAME_CHK_EN
    exp_res   = 2'd0;
`endif
    step();
    step();
    result("reset", 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Single-word frame
    word(2'd1, 1'b1);
    result("single", 1'b1, 2'd1, 4'd1, 1'b0, 1'b0);
    step();
    chk("single.drop", 32'(out_valid), 32'd0);

    // Three-word frame 1,2,2 -> 5 mod 3 = 2
    word(2'd1, 1'b0);
    chk("three.mid_valid", 32'(out_valid), 32'd0);
    word(2'd2, 1'b0);
    word(2'd2, 1'b1);
    result("three", 1'b1, 2'd2, 4'd3, 1'b0, 1'b0);
    step();

    // Backpressure: frame A = 1,2 -> res 0, cnt 2, then held
    word(2'd1, 1'b0);
    out_ready = 1'b0;
    word(2'd2, 1'b1);
    result("bpA", 1'b1, 2'd0, 4'd2, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_r     = 2'd2;
    in_last  = 1'b1;
    chk("bp.in_ready_low", 32'(in_ready), 32'd0);
    step();
    result("bpA_hold1", 1'b1, 2'd0, 4'd2, 1'b0, 1'b0);
    step();
    result("bpA_hold2", 1'b1, 2'd0, 4'd2, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_high", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    result("bpB", 1'b1, 2'd2, 4'd1, 1'b0, 1'b0);
    step();
    chk("bpB.drop", 32'(out_valid), 32'd0);

    // Back-to-back single-word frames with out_ready high: no bubble
    word(2'd1, 1'b1);
    result("b2b_1", 1'b1, 2'd1, 4'd1, 1'b0, 1'b0);
    chk("b2b.in_ready", 32'(in_ready), 32'd1);
    word(2'd2, 1'b1);
    result("b2b_2", 1'b1, 2'd2, 4'd1, 1'b0, 1'b0);
    step();

    // Illegal code: 2,3,1 -> 2+0+1 = 3 -> 0, err
    word(2'd2, 1'b0);
    word(2'd3, 1'b0);
    word(2'd1, 1'b1);
    result("illegal", 1'b1, 2'd0, 4'd3, 1'b0, 1'b1);
    step();

    // Saturation: 20 words of 1 -> count pinned at 15, 20 mod 3 = 2, err cleared
    for (int i = 0; i < 20; i++) begin
      word(2'd1, (i == 19));
    end
    result("sat", 1'b1, 2'd2, 4'd15, 1'b1, 1'b0);
    step();

    // Reset mid-frame: partial 1,1 discarded
    word(2'd1, 1'b0);
    word(2'd1, 1'b0);
    rst_n = 1'b0;
    step();
    result("midrst", 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    word(2'd2, 1'b1);
    result("after_rst", 1'b1, 2'd2, 4'd1, 1'b0, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mod3_frame_acc.md
MOD3_FRAME_ACC -- requirements
Module: mod3_frame_acc

Purpose: downstream stage of the registered divide-by-3 remainder path. It consumes a stream of 2-bit word remainders and produces the residue mod 3 of a multi-word big integer, streamed most-significant word first. Because 2^32 mod 3 = 1, the frame residue equals the sum of the word remainders mod 3.

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the frame word counter.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  in_r/in_last are valid this cycle.
REQ-005 in_ready  output  1  block accepts the input this cycle.
REQ-006 in_r  input  2  remainder of one 32-bit word mod 3; legal values are 0..2.
REQ-007 in_last  input  1  marks the final word of a frame.
REQ-008 out_valid  output  1  frame result is held.
REQ-009 out_ready  input  1  consumer takes the result.
REQ-010 out_res  output  2  frame residue mod 3.
REQ-011 out_cnt  output  CNT_W  number of words in the frame, saturating.
REQ-012 out_sat  output  1  out_cnt saturated during the frame.
REQ-013 out_err  output  1  at least one illegal in_r (3) was seen in the frame.

Function
REQ-014 Accept condition: a word SHALL be accepted only when in_valid && in_ready; in_ready = !out_valid || out_ready, and it SHALL be combinational from registered out_valid and input out_ready.
REQ-015 The block SHALL have two states, IDLE (no frame open) and ACCUM (frame open); IDLE->ACCUM on an accepted word with !in_last; ACCUM->IDLE on an accepted word with in_last; a single-word frame SHALL stay in IDLE.
REQ-016 Accumulation: the first accepted word of a frame SHALL load acc=in_r; each later word SHALL set acc=(acc+in_r) mod 3, using a 3-bit sum reduced by subtracting 3 when it is >=3.
REQ-017 An illegal in_r=3 SHALL be treated as 0 and SHALL set the frame error flag.
REQ-018 The word count SHALL increment per accepted word and SHALL saturate at 2^CNT_W-1, setting the frame sat flag.
REQ-019 Output timing: on accepting in_last, the cycle after SHALL present out_valid=1 with the final out_res, out_cnt, out_sat and out_err; internal acc, count and flags SHALL clear for the next frame.
REQ-020 Output hold: out_res, out_cnt, out_sat and out_err SHALL stay stable while out_valid && !out_ready; out_valid SHALL drop the cycle after out_ready when no new last word is accepted.
REQ-021 Simultaneous events: out_ready plus an accepted in_last in the same cycle SHALL reload the output register with no bubble, so out_valid stays 1.
REQ-022 Back-to-back frames SHALL sustain one word per cycle while out_ready=1.

Reset
REQ-023 When rst_n is low, the block SHALL force state=IDLE, acc=0, count=0, flags=0, out_valid=0, out_res=0, out_cnt=0, out_sat=0 and out_err=0; a partially accumulated frame SHALL be discarded.
REQ-024 After rst_n rises, the first accepted word SHALL start a new frame.

Configuration
REQ-025 With macro MOD3_FRAME_CHK_EN defined, the block SHALL add input exp_res[2] (sampled with the accepted in_last) and output out_mismatch, registered alongside out_res; out_mismatch=1 SHALL mean exp_res differs from the computed residue, and it SHALL reset to 0.
REQ-026 Without MOD3_FRAME_CHK_EN, neither exp_res nor out_mismatch SHALL exist and no compare logic SHALL be built.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, ACCUM), the constant MOD3=3, the illegal-code constant 2'b11 and the default CNT_W.
REQ-028 One sub-module, mod3_add (2-bit + 2-bit -> 2-bit mod 3, combinational), SHALL be used for the accumulate step.

Verification
REQ-029 Single-word frame: in_r=1, in_last=1 -> next cycle out_valid=1, out_res=1, out_cnt=1, out_err=0.
REQ-030 Three-word frame: in_r=1,2,2 with last on the third word -> out_res=2, out_cnt=3.
REQ-031 Backpressure: out_ready=0 while frame A (res 0) is held and frame B's last word is presented -> in_ready=0, the A result stays stable; raising out_ready -> B accepted the same cycle, B result out the next cycle.
REQ-032 Illegal code: frame in_r=2,3,1 -> out_res=0, out_err=1, out_cnt=3.
REQ-033 Saturation: CNT_W=4, 20-word frame of in_r=1 -> out_cnt=15, out_sat=1, out_res=2.
REQ-034 Reset mid-frame: assert rst_n low after 2 words (in_r=1,1), then send a frame of in_r=2 with last -> out_res=2, out_cnt=1.
